// File: rtl/fetch_ifid_if.sv
// Fetch-stage bus bundle: hazard/branch controls, instruction-memory port and IF/ID outputs.
// flush_count is present only when IFID_FLUSH_CNT_EN is defined.
interface fetch_ifid_if;
    logic        stall;
    logic        valid_in;
    logic [15:0] redirect_pc;
    logic [15:0] imem_data;
    logic [15:0] imem_addr;
    logic [15:0] instr_IFID;
    logic [15:0] pc_IFID;
    logic [15:0] pc_plus1_IFID;
    logic        valid_out_IFID;
`ifdef IFID_FLUSH_CNT_EN
    logic [15:0] flush_count;
`endif

    modport master (
`ifdef IFID_FLUSH_CNT_EN
        output flush_count,
`endif
        input  stall,
        input  valid_in,
        input  redirect_pc,
        input  imem_data,
        output imem_addr,
        output instr_IFID,
        output pc_IFID,
        output pc_plus1_IFID,
        output valid_out_IFID
    );

    modport slave (
`ifdef IFID_FLUSH_CNT_EN
        input  flush_count,
`endif
        output stall,
        output valid_in,
        output redirect_pc,
        output imem_data,
        input  imem_addr,
        input  instr_IFID,
        input  pc_IFID,
        input  pc_plus1_IFID,
        input  valid_out_IFID
    );
endinterface

// File: rtl/fetch_ifid.sv
// Instruction-fetch stage and IF/ID register for the 16-bit core.
// Optional saturating flush counter enabled by defining IFID_FLUSH_CNT_EN.
module fetch_ifid #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic          clk,
    input  logic          rst,
    fetch_ifid_if.master  bus
);

    logic [15:0] pc_r;
    logic [15:0] instr_r;
    logic [15:0] pc_ifid_r;
    logic [15:0] pc_plus1_r;
    logic        valid_r;
    logic [15:0] pc_inc_s;

    assign pc_inc_s = pc_r + 16'h0001;

    // PC and IF/ID register: reset, then flush, then stall, then advance.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_r       <= RESET_PC;
            instr_r    <= 16'h0000;
            pc_ifid_r  <= 16'h0000;
            pc_plus1_r <= 16'h0000;
            valid_r    <= 1'b0;
        end else if (!bus.valid_in) begin
            // Squash the wrong-path fetch; pc_IFID/pc_plus1_IFID keep their last values.
            pc_r       <= bus.redirect_pc;
            instr_r    <= 16'h0000;
            pc_ifid_r  <= pc_ifid_r;
            pc_plus1_r <= pc_plus1_r;
            valid_r    <= 1'b0;
        end else if (bus.stall) begin
            pc_r       <= pc_r;
            instr_r    <= instr_r;
            pc_ifid_r  <= pc_ifid_r;
            pc_plus1_r <= pc_plus1_r;
            valid_r    <= valid_r;
        end else begin
            pc_r       <= pc_inc_s;
            instr_r    <= bus.imem_data;
            pc_ifid_r  <= pc_r;
            pc_plus1_r <= pc_inc_s;
            valid_r    <= 1'b1;
        end
    end

`ifdef IFID_FLUSH_CNT_EN
    logic [15:0] flush_cnt_r;

    // Saturating count of flush edges; a flush is counted even while stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            flush_cnt_r <= 16'h0000;
        end else if (!bus.valid_in && (flush_cnt_r != 16'hFFFF)) begin
            flush_cnt_r <= flush_cnt_r + 16'h0001;
        end else begin
            flush_cnt_r <= flush_cnt_r;
        end
    end

    assign bus.flush_count = flush_cnt_r;
`endif

    assign bus.imem_addr      = pc_r;
    assign bus.instr_IFID     = instr_r;
    assign bus.pc_IFID        = pc_ifid_r;
    assign bus.pc_plus1_IFID  = pc_plus1_r;
    assign bus.valid_out_IFID = valid_r;

endmodule

// File: doc/fetch_ifid.md
# fetch_ifid

Instruction-fetch stage and IF/ID pipeline register for the 16-bit core. Holds the program counter, drives the instruction-memory address, and latches the fetched instruction, its PC and its link address into IF/ID. It consumes the ID-stage branch resolution signal `valid_in` (low = taken BEQ/JAL/JLR/JRI) to squash the wrong-path instruction and redirect the PC. It produces `valid_out_IFID`, which feeds back into that same branch logic.

## Interface
- `RESET_PC`, 16'h0000: PC value loaded on reset.
- `clk` input 1: single clock, all state updates on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `stall` input 1: hazard-unit stall; freezes PC and IF/ID.
- `valid_in` input 1: from ID branch logic; 0 = branch/jump taken, squash and redirect; 1 = continue.
- `redirect_pc` input 16: target PC, sampled when `valid_in`=0.
- `imem_data` input 16: instruction word at `imem_addr`, combinational read.
- `imem_addr` output 16: current PC.
- `instr_IFID` output 16: latched instruction.
- `pc_IFID` output 16: PC of the latched instruction.
- `pc_plus1_IFID` output 16: `pc_IFID`+1, the JAL/JLR link value.
- `valid_out_IFID` output 1: IF/ID holds a live instruction.
- `flush_count` output 16: present only with `IFID_FLUSH_CNT_EN`.

## Operation
- PC is word-addressed. Sequential increment is +1, modulo 2^16, so 16'hFFFF wraps to 16'h0000.
- `imem_addr` = `pc` combinationally. There is no other path from inputs to outputs.
- Per-edge priority, highest first:
  - **`rst`=1:** `pc`←`RESET_PC`; `instr_IFID`←0; `pc_IFID`←0; `pc_plus1_IFID`←0; `valid_out_IFID`←0; `flush_count`←0.
  - **`valid_in`=0 (flush):** `pc`←`redirect_pc`; `valid_out_IFID`←0; `instr_IFID`←0. `pc_IFID` and `pc_plus1_IFID` hold. Flush overrides `stall`.
  - **`stall`=1:** every register holds, including `valid_out_IFID`.
  - **Otherwise (advance):** `instr_IFID`←`imem_data`; `pc_IFID`←`pc`; `pc_plus1_IFID`←`pc`+1; `valid_out_IFID`←1; `pc`←`pc`+1.
- A bubble (`valid_out_IFID`=0) never causes a flush. The branch logic drives `valid_in`=1 whenever `valid_out_IFID`=0, and the block needs no extra gating for this.
- After a flush, the instruction at `redirect_pc` is captured on the next advance edge.
- Back-to-back flushes: each flush reloads `pc` from `redirect_pc`, so the last one wins.
- `rst` asserted mid-stall or mid-flush: reset takes effect on that edge with no residual state.
- X on `imem_data` while flushing or stalled must not propagate to `instr_IFID`.

## Timing
- Reset values: `imem_addr`=`RESET_PC`; all IF/ID outputs 0; `flush_count`=0.
- First edge with `rst`=0 and no stall captures the instruction at `RESET_PC`. `valid_out_IFID` goes high one cycle after reset deasserts.
- Fetch-to-IF/ID latency is 1 cycle.
- Taken-branch penalty is 1 bubble: the flush edge kills the wrong-path fetch, and the target is latched on the next edge.
- `stall` acts on the same edge it is sampled high. It has no pipeline delay.

## Configuration
- **`IFID_FLUSH_CNT_EN` defined:** adds `flush_count`, a 16-bit counter.
  - +1 on every edge where `rst`=0 and `valid_in`=0.
  - Saturates at 16'hFFFF and does not wrap.
  - Reset value is 0.
  - Counts even when `stall`=1 on the same edge, since flush has priority.
- **`IFID_FLUSH_CNT_EN` undefined:** the `flush_count` port and its logic are absent. All other behaviour is identical.

## Test plan
- **Reset then free-run:** `RESET_PC`=16'h0010; hold `rst` 2 cycles, then release with `stall`=0 and `valid_in`=1, with imem returning addr^16'hA5A5.
  - Required: `valid_out_IFID` is 0 during reset.
  - Cycle 1 after release: `pc_IFID`=16'h0010, `instr_IFID`=16'hA5B5, `pc_plus1_IFID`=16'h0011.
  - `imem_addr` increments by 1 per cycle.
- **Stall for 3 cycles at PC 16'h0014:** `imem_addr` holds at 16'h0014, and all IF/ID outputs are frozen. On release the next capture has `pc_IFID`=16'h0014.
- **Flush:** `valid_in`=0 for one cycle with `redirect_pc`=16'h0200.
  - Next cycle: `valid_out_IFID`=0, `instr_IFID`=0, `imem_addr`=16'h0200.
  - The following cycle: `pc_IFID`=16'h0200 and `valid_out_IFID`=1.
  - With `IFID_FLUSH_CNT_EN` defined, `flush_count`=1.
- **Flush and stall on the same edge,** `redirect_pc`=16'h0300: flush wins; `imem_addr`=16'h0300 and `valid_out_IFID`=0.
- **Wrap-around:** `RESET_PC`=16'hFFFE, free-run. Captured `pc_IFID` sequence is FFFE, FFFF, 0000; `pc_plus1_IFID`=0000 when `pc_IFID`=FFFF.
- **Mid-operation reset and counter saturation:**
  - Assert `rst` during a flush with `redirect_pc`=16'h0400. Next cycle: `imem_addr`=`RESET_PC`, `valid_out_IFID`=0, `flush_count`=0.
  - With `IFID_FLUSH_CNT_EN` defined, force 70000 flushes: `flush_count` reads 16'hFFFF.
